// File: rtl/slope_adc.sv
//==============================================================================
// Module   : slope_adc
// Purpose  : Single-slope ADC controller. On start it drives a rising
//            staircase code to an external DAC, one step per divider tick,
//            and latches the code at which the external comparator trips.
//            The result is reported with a one-cycle valid pulse.
// Ports    : clk_i   - system clock
//            rst_i   - synchronous active-high reset
//            start_i - conversion request, sampled in IDLE only
//            comp_i  - asynchronous comparator (high: ramp >= analog input)
//            ramp_o  - code driven to the DAC
//            data_o  - last conversion result
//            valid_o - one-cycle pulse when data_o updates
//            ovf_o   - comparator never tripped during the last conversion
//            busy_o  - conversion in progress (RAMP or DONE)
// Options  : SLOPE_ADC_FILTER_EN - require 4 consecutive synchronized
//            comparator-high samples before detection.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module slope_adc #(
  parameter int Width    = 10,
  parameter int Div      = 100_000,
  parameter int DivWidth = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             comp_i,
  output logic [Width-1:0] ramp_o,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DivWidth-1:0] DIV_LAST = DivWidth'(Div - 1);
  localparam logic [Width-1:0]    RAMP_MAX = '1;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [DivWidth-1:0] div_cnt;
  logic                tick;
  logic                comp_meta;
  logic                comp_s;
  logic                comp_det;

  // Two-flop synchronizer for the asynchronous comparator.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      comp_meta <= comp_i;
      comp_s    <= comp_meta;
    end
  end

`ifdef SLOPE_ADC_FILTER_EN
  // Detection needs the current sample plus the three previous ones high,
  // so comparator chatter shorter than four cycles never latches a result.
  logic [2:0] comp_hist;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      comp_hist <= 3'b000;
    end else begin
      comp_hist <= {comp_hist[1:0], comp_s};
    end
  end

  assign comp_det = comp_s & (&comp_hist);
`else
  assign comp_det = comp_s;
`endif

  assign tick = (state == S_RAMP) && (div_cnt == DIV_LAST);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; comparator takes priority over the tick.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start_i) state_next = S_RAMP;
      S_RAMP: begin
        if (comp_det) begin
          state_next = S_DONE;
        end else if (tick && (ramp_o == RAMP_MAX)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    valid_o = 1'b0;
    busy_o  = 1'b0;
    case (state)
      S_RAMP: busy_o = 1'b1;
      S_DONE: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: step divider, ramp code and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      ramp_o  <= '0;
      data_o  <= '0;
      ovf_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Divider starts from zero on entry to RAMP so the first step
          // lands exactly Div cycles after the start edge.
          div_cnt <= '0;
        end
        S_RAMP: begin
          div_cnt <= tick ? '0 : div_cnt + DivWidth'(1);
          if (comp_det) begin
            data_o <= ramp_o;
            ovf_o  <= 1'b0;
          end else if (tick) begin
            if (ramp_o == RAMP_MAX) begin
              data_o <= RAMP_MAX;
              ovf_o  <= 1'b1;
            end else begin
              ramp_o <= ramp_o + Width'(1);
            end
          end
        end
        S_DONE: begin
          // Final code is shown during DONE; IDLE always presents zero.
          ramp_o <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slope_adc.sv
`timescale 1ns/1ps
`default_nettype none

module tb_slope_adc;

  localparam int W  = 4;
  localparam int D  = 16;
  localparam int DW = 4;

`ifdef SLOPE_ADC_FILTER_EN
  localparam int FLT        = 3;
  localparam int GLITCH_RES = 8;
  localparam int GLITCH_CYC = 136;
`else
  localparam int FLT        = 0;
  localparam int GLITCH_RES = 4;
  localparam int GLITCH_CYC = 69;
`endif

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         comp_i = 1'b0;
  logic [W-1:0] ramp_o;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         ovf_o;
  logic         busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  slope_adc #(.Width(W), .Div(D), .DivWidth(DW)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .comp_i  (comp_i),
    .ramp_o  (ramp_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  // code: ramp code at which comp_i rises 2 cycles later (-1 = never)
  // exp_cyc: cycles after the start edge at which valid_o is seen
  typedef struct {
    int       code;
    bit       tied;
    int       exp_data;
    int       exp_ovf;
    int       exp_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_conv(input int idx, input vec_t v);
    bit seen = 0;
    int cnt = 0;
    int valid_n = 0;
    int vcyc = -1;
    int max_cyc = -1;
    int d = 0, o = 0, b = 0;
    comp_i = v.tied;
    if (v.tied) repeat (8) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (valid_o) begin
        valid_n++;
        if (vcyc < 0) begin
          vcyc = cyc; d = int'(data_o); o = int'(ovf_o); b = int'(busy_o);
        end
      end
      if (max_cyc < 0 && int'(ramp_o) == (1 << W) - 1) max_cyc = cyc;
      if (vcyc >= 0 && cyc == vcyc + 1) begin
        chk($sformatf("v%0d.post_valid", idx), int'(valid_o), 0);
        chk($sformatf("v%0d.post_busy", idx), int'(busy_o), 0);
        chk($sformatf("v%0d.post_ramp", idx), int'(ramp_o), 0);
      end
      if (vcyc >= 0 && cyc == vcyc + 3) break;
      if (!v.tied && v.code >= 0 && vcyc < 0) begin
        if (seen) cnt++;
        if (!seen && int'(ramp_o) == v.code) begin seen = 1; cnt = 0; end
        if (seen && cnt == 2) comp_i = 1'b1;
      end
    end
    comp_i = 1'b0;
    if (vcyc < 0) chk($sformatf("v%0d.timeout", idx), 0, 1);
    chk($sformatf("v%0d.valid_cnt", idx), valid_n, 1);
    chk($sformatf("v%0d.valid_cyc", idx), vcyc, v.exp_cyc);
    chk($sformatf("v%0d.data", idx), d, v.exp_data);
    chk($sformatf("v%0d.ovf", idx), o, v.exp_ovf);
    chk($sformatf("v%0d.busy_at_valid", idx), b, 1);
    if (!v.tied && v.code < 0) chk($sformatf("v%0d.ramp_max_cyc", idx), max_cyc, 240);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{-1, 1'b1,  0, 0, 1};
    vecs[1] = '{ 5, 1'b0,  5, 0, 85 + FLT};
    vecs[2] = '{-1, 1'b0, 15, 1, 256};
    vecs[3] = '{ 5, 1'b0,  5, 0, 85 + FLT};
    vecs[4] = '{ 0, 1'b0,  0, 0, 5 + FLT};
    vecs[5] = '{15, 1'b0, 15, 0, 245 + FLT};
    vecs[6] = '{ 3, 1'b0,  3, 0, 53 + FLT};
    vecs[7] = '{ 9, 1'b0,  9, 0, 149 + FLT};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.ramp", int'(ramp_o), 0);
    chk("rst.data", int'(data_o), 0);
    chk("rst.valid", int'(valid_o), 0);
    chk("rst.ovf", int'(ovf_o), 0);
    chk("rst.busy", int'(busy_o), 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_conv(i, vecs[i]);

    // Reset mid-ramp at code 7
    begin
      int valid_n = 0;
      bit hit = 0;
      int vcyc = -1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        @(negedge clk);
        if (valid_o) valid_n++;
        if (int'(ramp_o) == 7) begin hit = 1; break; end
      end
      chk("rstmid.reached7", int'(hit), 1);
      rst_i = 1'b1;
      @(negedge clk);
      chk("rstmid.ramp", int'(ramp_o), 0);
      chk("rstmid.data", int'(data_o), 0);
      chk("rstmid.valid", int'(valid_o), 0);
      chk("rstmid.ovf", int'(ovf_o), 0);
      chk("rstmid.busy", int'(busy_o), 0);
      rst_i = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (valid_o) valid_n++;
      end
      chk("rstmid.no_valid", valid_n, 0);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("restart.ramp0", int'(ramp_o), 0);
      chk("restart.busy", int'(busy_o), 1);
      repeat (15) @(negedge clk);
      chk("restart.ramp_before_step", int'(ramp_o), 0);
      @(negedge clk);
      chk("restart.ramp_step1", int'(ramp_o), 1);
      comp_i = 1'b1;
      for (int cyc = 0; cyc < 50; cyc++) begin
        @(negedge clk);
        if (valid_o) begin vcyc = cyc; break; end
      end
      chk("restart.valid_seen", int'(vcyc >= 0), 1);
      chk("restart.data", int'(data_o), 1);
      comp_i = 1'b0;
      repeat (6) @(negedge clk);
    end

    // Back-to-back conversions with start_i held high
    begin
      int targets[2];
      int k = 0;
      bit seen = 0;
      int cnt = 0;
      int v1 = -1, v2 = -1;
      targets[0] = 3;
      targets[1] = 9;
      start_i = 1'b1;
      for (int cyc = 0; cyc < 700; cyc++) begin
        @(negedge clk);
        if (v1 >= 0 && cyc == v1 + 1) begin
          chk("b2b.gap_busy", int'(busy_o), 0);
          chk("b2b.gap_ramp", int'(ramp_o), 0);
        end
        if (v1 >= 0 && cyc == v1 + 2) chk("b2b.restart_busy", int'(busy_o), 1);
        if (v2 >= 0 && cyc == v2 + 3) break;
        if (valid_o && k < 2) begin
          chk($sformatf("b2b.data%0d", k), int'(data_o), targets[k]);
          if (k == 0) v1 = cyc; else v2 = cyc;
          comp_i = 1'b0;
          seen = 0;
          k++;
          if (k == 2) start_i = 1'b0;
        end else if (valid_o) begin
          chk("b2b.extra_valid", 1, 0);
        end else if (k < 2) begin
          if (seen) cnt++;
          if (!seen && int'(ramp_o) == targets[k]) begin seen = 1; cnt = 0; end
          if (seen && cnt == 2) comp_i = 1'b1;
        end
      end
      start_i = 1'b0;
      comp_i  = 1'b0;
      chk("b2b.valid_count", k, 2);
      chk("b2b.spacing", v2 - v1, 151 + FLT);
      repeat (6) @(negedge clk);
    end

    // Comparator glitch at code 4, sustained high from code 8
    begin
      bit s4 = 0, s8 = 0;
      int c4 = 0, c8 = 0;
      int vcyc = -1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        if (cyc > 0) @(negedge clk);
        if (valid_o) begin vcyc = cyc; break; end
        if (s4) c4++;
        if (s8) c8++;
        if (!s4 && int'(ramp_o) == 4) begin s4 = 1; c4 = 0; end
        if (!s8 && int'(ramp_o) == 8) begin s8 = 1; c8 = 0; end
        if (s4 && c4 == 2) comp_i = 1'b1;
        if (s4 && c4 == 4) comp_i = 1'b0;
        if (s8 && c8 == 2) comp_i = 1'b1;
      end
      chk("glitch.valid_cyc", vcyc, GLITCH_CYC);
      chk("glitch.data", int'(data_o), GLITCH_RES);
      chk("glitch.ovf", int'(ovf_o), 0);
      comp_i = 1'b0;
      repeat (6) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
